systolic_result_drain: RTL and testbench



---
 rtl/systolic_pkg.sv | 11 +
 rtl/sat_clamp8.sv | 11 +
 rtl/systolic_result_drain.sv | 72 +++++++
 tb/tb_systolic_result_drain.sv | 228 ++++++++++++++++++++++
 4 files changed

// File: rtl/systolic_pkg.sv
// systolic_pkg: shared sizes, drain state encoding and packed-bus word slicing for the result drain
package systolic_pkg;
  localparam int N = 3;
  localparam int ACC_W = 32;
  localparam int IDX_W = 4;
  localparam int NW = N * N;
  typedef enum logic {IDLE, STREAM} state_t;
  function automatic logic [ACC_W-1:0] word_at(input logic [NW*ACC_W-1:0] bus, input int k);
    return bus[k*ACC_W +: ACC_W];
  endfunction
endpackage

// File: rtl/sat_clamp8.sv
// sat_clamp8: unsigned clamp of one accumulator word to 8 bits (only built with SYSTOLIC_DRAIN_SAT8_EN)
`ifdef SYSTOLIC_DRAIN_SAT8_EN
module sat_clamp8
  import systolic_pkg::*;
(
  input  logic [ACC_W-1:0] din,
  output logic [7:0]       dout
);
  assign dout = (din > ACC_W'(255)) ? 8'hFF : din[7:0];
endmodule
`endif

// File: rtl/systolic_result_drain.sv
// systolic_result_drain: snapshots results on a mat_done rise and streams them row-major over valid/ready; SYSTOLIC_DRAIN_SAT8_EN clamps words to 8 bits
module systolic_result_drain
  import systolic_pkg::*;
(
  input  logic                clk,
  input  logic                rst,
  input  logic [NW*ACC_W-1:0] mat_in,
  input  logic                mat_done,
  output logic                m_valid,
  input  logic                m_ready,
  output logic [ACC_W-1:0]    m_data,
  output logic [IDX_W-1:0]    m_index,
  output logic                m_last,
  output logic                busy,
  output logic                overrun
);
  state_t           state_q, state_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [ACC_W-1:0] snap_q [NW];
  logic [ACC_W-1:0] snap_d [NW];
  logic [ACC_W-1:0] cap_w [NW];
  logic             done_q, overrun_q, overrun_d, done_rise, hs, at_last;
  for (genvar g = 0; g < NW; g++) begin : g_cap
`ifdef SYSTOLIC_DRAIN_SAT8_EN
    logic [7:0] c8;
    sat_clamp8 u_clamp (.din(word_at(mat_in, g)), .dout(c8));
    assign cap_w[g] = {{(ACC_W-8){1'b0}}, c8};
`else
    assign cap_w[g] = word_at(mat_in, g);
`endif
  end
  // a rise while idle or on the final handshake captures; a rise mid-stream only flags overrun
  always_comb begin
    done_rise = mat_done & ~done_q;
    hs        = (state_q == STREAM) & m_ready;
    at_last   = idx_q == IDX_W'(NW - 1);
    state_d   = state_q;
    idx_d     = idx_q;
    snap_d    = snap_q;
    overrun_d = overrun_q;
    if (state_q == IDLE || (hs && at_last)) begin
      state_d = done_rise ? STREAM : IDLE;
      idx_d   = '0;
      if (done_rise) snap_d = cap_w;
    end else begin
      overrun_d = overrun_q | done_rise;
      idx_d     = hs ? idx_q + 1'b1 : idx_q;
    end
  end
  // state, snapshot and edge-detect registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      idx_q     <= '0;
      done_q    <= 1'b0;
      overrun_q <= 1'b0;
      snap_q    <= '{default: '0};
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      done_q    <= mat_done;
      overrun_q <= overrun_d;
      snap_q    <= snap_d;
    end
  end
  assign m_valid = state_q == STREAM;
  assign busy    = m_valid;
  assign m_index = idx_q;
  assign m_last  = m_valid & at_last;
  assign m_data  = m_valid ? snap_q[idx_q] : '0;
  assign overrun = overrun_q;
endmodule

// File: tb/tb_systolic_result_drain.sv
// tb_systolic_result_drain: vector tables, hand sequences and a queue-based random model for the result drain
module tb_systolic_result_drain;
  import systolic_pkg::*;
  logic                clk = 1'b0;
  logic                rst = 1'b1;
  logic                mat_done = 1'b0;
  logic                m_ready = 1'b0;
  logic [NW*ACC_W-1:0] mat_in = '0;
  logic                m_valid, m_last, busy, overrun;
  logic [ACC_W-1:0]    m_data;
  logic [IDX_W-1:0]    m_index;
  int                  n_cmp = 0;
  int                  n_bad = 0;
  typedef struct {
    logic             rdy;
    logic             valid;
    int               idx;
    logic [ACC_W-1:0] data;
    logic             last;
  } vec_t;
  vec_t vecs[$];
  typedef struct {
    int               idx;
    logic [ACC_W-1:0] d;
  } word_t;
  word_t q[$];
  logic  prev_done, ovr;
  systolic_result_drain dut (
    .clk(clk), .rst(rst), .mat_in(mat_in), .mat_done(mat_done),
    .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data), .m_index(m_index),
    .m_last(m_last), .busy(busy), .overrun(overrun)
  );
  always #5 clk = ~clk;
  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask
  task automatic step;
    @(posedge clk);
    #1;
  endtask
  task automatic set_mat(input int base);
    for (int k = 0; k < NW; k++) mat_in[k*ACC_W +: ACC_W] = ACC_W'(base + k);
  endtask
  function automatic logic [ACC_W-1:0] exp_word(input logic [ACC_W-1:0] v);
`ifdef SYSTOLIC_DRAIN_SAT8_EN
    return (v > ACC_W'(255)) ? ACC_W'(255) : v;
`else
    return v;
`endif
  endfunction
  task automatic chk_out(input string tag, input logic v, input int idx, input logic [ACC_W-1:0] d, input logic l);
    chk({tag, ".valid"}, 64'(m_valid), 64'(v));
    chk({tag, ".busy"}, 64'(busy), 64'(v));
    chk({tag, ".last"}, 64'(m_last), 64'(l));
    if (v) begin
      chk({tag, ".index"}, 64'(m_index), 64'(idx));
      chk({tag, ".data"}, 64'(m_data), 64'(d));
    end
  endtask
  task automatic run_vecs(input string tag);
    foreach (vecs[i]) begin
      m_ready = vecs[i].rdy;
      @(negedge clk);
      chk_out($sformatf("%s[%0d]", tag, i), vecs[i].valid, vecs[i].idx, vecs[i].data, vecs[i].last);
      step;
    end
  endtask
  task automatic do_reset;
    rst = 1'b1;
    step;
    step;
    rst = 1'b0;
  endtask
  initial begin
    do_reset;
    @(negedge clk);
    chk_out("reset", 1'b0, 0, '0, 1'b0);
    chk("reset.data", 64'(m_data), 64'd0);
    chk("reset.index", 64'(m_index), 64'd0);
    chk("reset.overrun", 64'(overrun), 64'd0);
    // full-rate drain, mat_done held high afterwards
    step;
    set_mat(100);
    m_ready = 1'b1;
    mat_done = 1'b1;
    @(negedge clk);
    chk("t1.pre_capture_valid", 64'(m_valid), 64'd0);
    step;
    vecs.delete();
    for (int r = 0; r < 12; r++)
      vecs.push_back('{rdy: 1'b1, valid: r < NW, idx: r, data: exp_word(ACC_W'(100 + r)), last: r == NW - 1});
    run_vecs("t1");
    mat_done = 1'b0;
    step;
    // stalled drain: ready pattern 1,0,0 repeating
    mat_done = 1'b1;
    step;
    vecs.delete();
    for (int r = 0; r < 26; r++)
      vecs.push_back('{rdy: (r % 3) == 0, valid: r < 25, idx: (r + 2) / 3,
                       data: exp_word(ACC_W'(100 + (r + 2) / 3)), last: (r + 2) / 3 == NW - 1});
    run_vecs("t2");
    mat_done = 1'b0;
    step;
    // snapshot isolation and overrun
    m_ready = 1'b1;
    mat_done = 1'b1;
    step;
    for (int c = 0; c < NW; c++) begin
      if (c == 2) begin
        for (int k = 0; k < NW; k++) mat_in[k*ACC_W +: ACC_W] = 32'hDEAD_BEEF;
        mat_done = 1'b0;
      end
      if (c == 3) mat_done = 1'b1;
      @(negedge clk);
      chk($sformatf("t3.index[%0d]", c), 64'(m_index), 64'(c));
      chk($sformatf("t3.data[%0d]", c), 64'(m_data), 64'(exp_word(ACC_W'(100 + c))));
      step;
    end
    @(negedge clk);
    chk("t3.valid_end", 64'(m_valid), 64'd0);
    chk("t3.overrun", 64'(overrun), 64'd1);
    step;
    step;
    @(negedge clk);
    chk("t3.no_recapture", 64'(m_valid), 64'd0);
    mat_done = 1'b0;
    step;
    @(negedge clk);
    chk("t3.overrun_sticky", 64'(overrun), 64'd1);
    // back-to-back capture on the final handshake
    do_reset;
    @(negedge clk);
    chk("t4.overrun_cleared", 64'(overrun), 64'd0);
    set_mat(100);
    mat_done = 1'b1;
    step;
    for (int c = 0; c < NW; c++) begin
      if (c == 7) mat_done = 1'b0;
      if (c == 8) begin
        mat_done = 1'b1;
        set_mat(200);
      end
      @(negedge clk);
      chk($sformatf("t4.a.index[%0d]", c), 64'(m_index), 64'(c));
      chk($sformatf("t4.a.data[%0d]", c), 64'(m_data), 64'(exp_word(ACC_W'(100 + c))));
      step;
    end
    for (int c = 0; c < NW; c++) begin
      @(negedge clk);
      chk_out($sformatf("t4.b[%0d]", c), 1'b1, c, exp_word(ACC_W'(200 + c)), c == NW - 1);
      chk($sformatf("t4.b.overrun[%0d]", c), 64'(overrun), 64'd0);
      step;
    end
    @(negedge clk);
    chk("t4.valid_end", 64'(m_valid), 64'd0);
    mat_done = 1'b0;
    step;
    // reset mid-stream, then mat_done still high restarts a capture
    set_mat(300);
    mat_done = 1'b1;
    step;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      chk($sformatf("t5.index[%0d]", c), 64'(m_index), 64'(c));
      chk($sformatf("t5.data[%0d]", c), 64'(m_data), 64'(exp_word(ACC_W'(300 + c))));
      if (c == 4) rst = 1'b1;
      step;
    end
    rst = 1'b0;
    set_mat(400);
    @(negedge clk);
    chk_out("t5.after_rst", 1'b0, 0, '0, 1'b0);
    chk("t5.after_rst.overrun", 64'(overrun), 64'd0);
    chk("t5.after_rst.index", 64'(m_index), 64'd0);
    chk("t5.after_rst.data", 64'(m_data), 64'd0);
    step;
    for (int c = 0; c < NW; c++) begin
      @(negedge clk);
      chk_out($sformatf("t5.restart[%0d]", c), 1'b1, c, exp_word(ACC_W'(400 + c)), c == NW - 1);
      step;
    end
    mat_done = 1'b0;
    // random traffic against a queue-of-pending-words model
    do_reset;
    q.delete();
    prev_done = 1'b0;
    ovr = 1'b0;
    for (int cyc = 0; cyc < 1500; cyc++) begin
      m_ready = ($urandom % 4) != 0;
      if ($urandom % 8 == 0) mat_done = ~mat_done;
      if ($urandom % 3 == 0)
        for (int k = 0; k < NW; k++)
          case ($urandom % 6)
            0: mat_in[k*ACC_W +: ACC_W] = 32'd255;
            1: mat_in[k*ACC_W +: ACC_W] = 32'd256;
            2: mat_in[k*ACC_W +: ACC_W] = 32'hFFFF_FFFF;
            3: mat_in[k*ACC_W +: ACC_W] = ACC_W'($urandom % 300);
            default: mat_in[k*ACC_W +: ACC_W] = $urandom;
          endcase
      @(negedge clk);
      chk("rnd.valid", 64'(m_valid), 64'(q.size() > 0));
      chk("rnd.busy", 64'(busy), 64'(q.size() > 0));
      chk("rnd.overrun", 64'(overrun), 64'(ovr));
      if (q.size() > 0) begin
        chk("rnd.index", 64'(m_index), 64'(q[0].idx));
        chk("rnd.data", 64'(m_data), 64'(q[0].d));
        chk("rnd.last", 64'(m_last), 64'(q[0].idx == NW - 1));
      end
      @(posedge clk);
      if (q.size() > 0 && m_ready) void'(q.pop_front());
      if (mat_done && !prev_done) begin
        if (q.size() == 0)
          for (int k = 0; k < NW; k++) q.push_back('{idx: k, d: exp_word(mat_in[k*ACC_W +: ACC_W])});
        else
          ovr = 1'b1;
      end
      prev_done = mat_done;
      #1;
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
